gshare_predictor: RTL

Parametrised second-generation gshare direction predictor for the fetch stage of the MIPS pipeline. Predicts taken/not-taken from the fetch word address XOR a speculative global history register, and keeps an in-order checkpoint queue of in-flight predictions. Counters are trained only at resolution from the ALU stage. A mispredict restores history exactly from the checkpoint. After reset, a sweep FSM initialises the pattern table.

---
 rtl/gshare_predictor.sv | 108 ++++++++++
 1 files changed

// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare direction predictor with a checkpointed speculative history and an init sweep.
module gshare_predictor #(
    parameter int ADDRESS_WIDTH = 22,
    parameter int GHR_SIZE      = 8,
    parameter int INDEX_WIDTH   = 10,
    parameter int CTR_WIDTH     = 2,
    parameter int INFLIGHT      = 4
) (
    input  logic                             i_Clk,
    input  logic                             i_Reset_n,
    input  logic                             i_Pred_valid,
    input  logic [ADDRESS_WIDTH-1:0]         i_IMEM_address,
    input  logic                             i_Stall,
    input  logic                             i_Resolve_valid,
    input  logic                             i_Resolve_outcome,
    input  logic                             i_Flush,
    output logic                             o_taken,
    output logic                             o_Ready,
    output logic [$clog2(INFLIGHT+1)-1:0]    o_Inflight,
    output logic                             o_Mispredict,
    output logic [GHR_SIZE-1:0]              o_GHR
);
    localparam int PW = $clog2(INFLIGHT);
    localparam int CW = $clog2(INFLIGHT+1);
    localparam logic [CTR_WIDTH-1:0] WEAK = {1'b1, {(CTR_WIDTH-1){1'b0}}};
    typedef enum logic {INIT, RUN} state_t;
    state_t                  state;
    logic [INDEX_WIDTH-1:0]  sweep;
    logic [CTR_WIDTH-1:0]    pht [2**INDEX_WIDTH];
    logic [INDEX_WIDTH-1:0]  q_idx [INFLIGHT];
    logic                    q_pred [INFLIGHT];
    logic [GHR_SIZE-2:0]     q_ghr [INFLIGHT];
    logic [PW-1:0]           head, tail;
    logic [CW-1:0]           count;
    logic [GHR_SIZE-1:0]     ghr, arch_ghr, arch_next;
    logic [INDEX_WIDTH-1:0]  idx;
    logic [CTR_WIDTH-1:0]    head_ctr, head_ctr_next;
    logic                    run, pred, resolve, mispredict, flush, accept;
    logic                    unused_addr;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(INFLIGHT-1) ? '0 : p + 1'b1;
    endfunction
    assign unused_addr   = ^i_IMEM_address;
    assign run           = state == RUN;
    assign idx           = INDEX_WIDTH'(ghr) ^ i_IMEM_address[INDEX_WIDTH-1:0];
    assign pred          = pht[idx][CTR_WIDTH-1];
    assign o_taken       = run & pred;
    // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign o_Ready       = run & (count != CW'(INFLIGHT));
    assign resolve       = run & i_Resolve_valid & (count != '0);
    assign mispredict    = resolve & (i_Resolve_outcome != q_pred[head]);
    assign flush         = run & i_Flush;
    assign accept        = i_Pred_valid & o_Ready & ~i_Stall & ~i_Flush & ~mispredict;
    assign arch_next     = resolve ? {arch_ghr[GHR_SIZE-2:0], i_Resolve_outcome} : arch_ghr;
    assign head_ctr      = pht[q_idx[head]];
    assign head_ctr_next = i_Resolve_outcome ? (&head_ctr ? head_ctr : head_ctr + CTR_WIDTH'(1))
                                             : (|head_ctr ? head_ctr - CTR_WIDTH'(1) : head_ctr);
    assign o_Inflight    = count;
    assign o_GHR         = ghr;
    // The table is deliberately outside the reset domain; only the sweep initialises it.
    always_ff @(posedge i_Clk) begin
        if (!run)
            pht[sweep] <= WEAK;
        else if (resolve)
            pht[q_idx[head]] <= head_ctr_next;
    end
    always_ff @(posedge i_Clk) begin
        if (accept) begin
            q_idx[tail]  <= idx;
            q_pred[tail] <= pred;
            q_ghr[tail]  <= ghr[GHR_SIZE-2:0];
        end
    end
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state        <= INIT;
            sweep        <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ghr          <= '0;
            arch_ghr     <= '0;
            o_Mispredict <= 1'b0;
        end else begin
            o_Mispredict <= mispredict;
            arch_ghr     <= arch_next;
            if (!run) begin
                sweep <= sweep + 1'b1;
                if (&sweep)
                    state <= RUN;
            end
            if (flush | mispredict) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (resolve)
                    head <= inc(head);
                if (accept)
                    tail <= inc(tail);
                count <= count + CW'(accept) - CW'(resolve);
            end
            ghr <= flush      ? arch_next :
                   mispredict ? {q_ghr[head], i_Resolve_outcome} :
                   accept     ? {ghr[GHR_SIZE-2:0], pred} : ghr;
        end
    end
endmodule
